// File: rtl/prime_pkg.sv
// Shared definitions for the prime sweep controller slice.
//   W_DEF     : default candidate/count width (matches prime unit sw width)
//   PRIME_RES : prime unit result value that means "prime"
//   state_t   : sweep sequencer states
package prime_pkg;

    localparam int   W_DEF     = 16;
    localparam logic PRIME_RES = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/prime_sweep_ctrl_if.sv
// Bus interfaces used by prime_sweep_ctrl.
//   prime_unit_if   : link to the prime-test unit
//       p_sw  candidate, p_go start pulse (master -> unit)
//       p_stp done, p_res result 0=prime (unit -> master)
//   prime_stream_if : valid/ready stream of primes
//       out_valid, out_data (master -> consumer), out_ready (consumer -> master)
interface prime_unit_if
    import prime_pkg::*;
#(
    parameter int W = W_DEF
);
    logic [W-1:0] p_sw;
    logic         p_go;
    logic         p_stp;
    logic         p_res;

    modport master (output p_sw, output p_go, input  p_stp, input  p_res);
    modport slave  (input  p_sw, input  p_go, output p_stp, output p_res);
endinterface

interface prime_stream_if
    import prime_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/prime_wdog.sv
// Loadable watchdog down-counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr_i       : force count to zero (highest priority)
//   load_i      : load load_val_i
//   en_i        : count down while waiting
//   expire_o    : high while enabled and the count has reached zero
// Loading N gives expiry on the (N+1)-th enabled cycle.
module prime_wdog
    import prime_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          expire_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/prime_sweep_ctrl.sv
// Sweeps an attached prime-test unit over [lo, hi] and streams primes out.
//   clk, rst_n   : clock, synchronous active-low reset
//   start, abort : sweep request / cancel (abort has priority)
//   lo, hi       : inclusive candidate range, sampled on accepted start
//   busy, done   : sweep in progress / one-cycle completion pulse
//   err          : sticky watchdog timeout, cleared on accepted start
//   count        : primes emitted this sweep, saturating
//   pu           : prime unit link (master side)
//   ps           : prime output stream (master side)
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | drive candidate, pulse p_go (skip if below MIN_CAND)
// SETTLE | one dead cycle, p_stp may still be stale from last candidate
// WAIT   | wait for p_stp, watchdog running
// EMIT   | hold prime on stream until accepted
// NEXT   | stop at last candidate or advance
// DONE   | one-cycle done pulse
module prime_sweep_ctrl
    import prime_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MIN_CAND = 2,
    parameter int WDOG     = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   lo,
    input  logic [W-1:0]   hi,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   count,
    prime_unit_if.master   pu,
    prime_stream_if.master ps
);

    localparam int            CW        = $clog2(WDOG + 1);
    localparam logic [CW-1:0] WDOG_LOAD = CW'(WDOG - 1);
    localparam logic [W-1:0]  MIN_C     = W'(MIN_CAND);

    state_t       state_q, state_d;
    logic [W-1:0] cur_q, cur_d;
    logic [W-1:0] last_q, last_d;
    logic [W-1:0] count_q, count_d;
    logic         err_q, err_d;
    logic [W-1:0] p_sw_q, p_sw_d;
    logic [W-1:0] out_data_q, out_data_d;

    logic go;
    logic valid;
    logic wd_load;
    logic wd_en;
    logic wd_expire;

    prime_wdog #(.CW(CW)) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (abort),
        .load_i     (wd_load),
        .load_val_i (WDOG_LOAD),
        .en_i       (wd_en),
        .expire_o   (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        count_d    = count_q;
        err_d      = err_q;
        p_sw_d     = p_sw_q;
        out_data_d = out_data_q;
        go         = 1'b0;
        valid      = 1'b0;
        wd_load    = 1'b0;
        wd_en      = 1'b0;

        if (abort) begin
            // Cancel outright: nothing issued or handed over this cycle.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_d   = lo;
                        last_d  = hi;
                        count_d = '0;
                        err_d   = 1'b0;
                        if (lo > hi) begin
                            state_d = ST_DONE;
                        end else begin
                            p_sw_d  = lo;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cur_q < MIN_C) begin
                        state_d = ST_NEXT;
                    end else begin
                        go      = 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    wd_load = 1'b1;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    wd_en = 1'b1;
                    if (pu.p_stp) begin
                        if (pu.p_res == PRIME_RES) begin
                            out_data_d = cur_q;
                            state_d    = ST_EMIT;
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end else if (wd_expire) begin
                        err_d   = 1'b1;
                        state_d = ST_NEXT;
                    end
                end
                ST_EMIT: begin
                    valid = 1'b1;
                    if (ps.out_ready) begin
                        if (count_q != {W{1'b1}}) begin
                            count_d = count_q + 1'b1;
                        end
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Compare before increment so hi = all-ones cannot wrap.
                    if (cur_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        p_sw_d  = cur_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            p_sw_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            count_q    <= count_d;
            err_q      <= err_d;
            p_sw_q     <= p_sw_d;
            out_data_q <= out_data_d;
        end
    end

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;
    assign count        = count_q;
    assign pu.p_sw      = p_sw_q;
    assign pu.p_go      = go;
    assign ps.out_valid = valid;
    assign ps.out_data  = out_data_q;

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Directed bench for prime_sweep_ctrl with a behavioural prime unit stub.
module tb_prime_sweep_ctrl;
    import prime_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] lo, hi;
    logic        busy, done, err;
    logic [15:0] count;

    prime_unit_if   #(.W(16)) pu ();
    prime_stream_if #(.W(16)) ps ();

    prime_sweep_ctrl #(.W(16), .MIN_CAND(2), .WDOG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .lo    (lo),
        .hi    (hi),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .count (count),
        .pu    (pu),
        .ps    (ps)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Prime unit stub: stp stays high (stale) into SETTLE, answers in WAIT4.
    logic        stuck;
    logic        pend;
    int          dly;
    logic [15:0] cand;

    always @(posedge clk) begin
        if (!rst_n) begin
            pu.p_stp <= 1'b0;
            pu.p_res <= 1'b0;
            pend     <= 1'b0;
            dly      <= 0;
            cand     <= '0;
        end else if (pu.p_go) begin
            pend <= 1'b1;
            dly  <= 3;
            cand <= pu.p_sw;
        end else if (pend) begin
            if (dly == 3) pu.p_stp <= 1'b0;
            if (dly == 0) begin
                if (!stuck) begin
                    pu.p_stp <= 1'b1;
                    pu.p_res <= !is_prime(int'(cand));
                end
                pend <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Consumer: always ready, or in stall mode holds ready low 5 cycles per prime.
    logic stall_mode;
    int   scnt;

    always begin
        @(posedge clk);
        #1;
        if (!stall_mode) begin
            ps.out_ready = 1'b1;
            scnt = 0;
        end else if (ps.out_valid) begin
            scnt++;
            ps.out_ready = (scnt > 5);
        end else begin
            scnt = 0;
            ps.out_ready = 1'b0;
        end
    end

    // Monitors
    int          cyc = 0;
    int          go_cnt, done_cnt, stall_cyc, viol;
    int          go_cyc, done_cyc, err_cyc;
    logic [15:0] go_q[$];
    logic [15:0] prime_q[$];
    logic [15:0] exp_q[$];
    logic        prev_stall, err_prev;
    logic [15:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pu.p_go) begin
            go_cnt++;
            go_cyc = cyc;
            go_q.push_back(pu.p_sw);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
        if (ps.out_valid && ps.out_ready) prime_q.push_back(ps.out_data);
        if (ps.out_valid && !ps.out_ready) stall_cyc++;
        if (ps.out_valid && prev_stall && (ps.out_data != prev_data)) viol++;
        prev_stall = ps.out_valid && !ps.out_ready;
        prev_data  = ps.out_data;
    end

    task automatic clear_mon();
        go_cnt = 0; done_cnt = 0; stall_cyc = 0; viol = 0;
        go_cyc = -1; done_cyc = -1; err_cyc = -1;
        go_q.delete();
        prime_q.delete();
    endtask

    task automatic run_sweep(input logic [15:0] l, input logic [15:0] h, output int lat);
        clear_mon();
        lo = l;
        hi = h;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            if (done) break;
            lat++;
        end
        if (lat >= 2000) chk("sweep_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_primes(input string tag);
        chk({tag, "_nprimes"}, prime_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < prime_q.size(); i++) begin
            chk($sformatf("%s_p%0d", tag, i), prime_q[i], exp_q[i]);
        end
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; lo = '0; hi = '0;
        stuck = 1'b0; stall_mode = 1'b0; ps.out_ready = 1'b1;
        err_prev = 1'b0; prev_stall = 1'b0; prev_data = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_p_go", pu.p_go, 0);
        chk("rst_p_sw", pu.p_sw, 0);
        chk("rst_valid", ps.out_valid, 0);
        chk("rst_data", ps.out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 3..20, no backpressure
        run_sweep(16'd3, 16'd20, lat);
        exp_q = '{16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19};
        chk_primes("t1");
        chk("t1_count", count, 7);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", err, 0);
        chk("t1_go", go_cnt, 18);
        chk("t1_busy", busy, 0);

        // 0..3: 0 and 1 skipped
        run_sweep(16'd0, 16'd3, lat);
        exp_q = '{16'd2, 16'd3};
        chk_primes("t2");
        chk("t2_count", count, 2);
        chk("t2_go", go_cnt, 2);
        chk("t2_first_sw", (go_q.size() > 0) ? go_q[0] : 16'hFFFF, 2);

        // lo > hi
        run_sweep(16'd10, 16'd5, lat);
        chk("t3_lat", lat, 0);
        chk("t3_go", go_cnt, 0);
        chk("t3_count", count, 0);
        chk("t3_done", done_cnt, 1);

        // 3..11 with 5-cycle stalls
        stall_mode = 1'b1;
        run_sweep(16'd3, 16'd11, lat);
        stall_mode = 1'b0;
        exp_q = '{16'd3, 16'd5, 16'd7, 16'd11};
        chk_primes("t4");
        chk("t4_count", count, 4);
        chk("t4_stall_cyc", stall_cyc, 20);
        chk("t4_unstable", viol, 0);

        // top of range: only 65521 is prime; must stop at 65535
        run_sweep(16'd65520, 16'd65535, lat);
        exp_q = '{16'd65521};
        chk_primes("t5");
        chk("t5_count", count, 1);
        chk("t5_go", go_cnt, 16);
        chk("t5_done", done_cnt, 1);
        chk("t5_busy", busy, 0);

        // watchdog with stuck unit
        stuck = 1'b1;
        run_sweep(16'd7, 16'd7, lat);
        chk("t6_err", err, 1);
        chk("t6_count", count, 0);
        chk("t6_done", done_cnt, 1);
        chk("t6_err_cyc", err_cyc - go_cyc, 10);
        chk("t6_done_cyc", done_cyc - go_cyc, 11);

        // abort mid-WAIT
        clear_mon();
        lo = 16'd7; hi = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("t7_err_cleared", err, 0);
        chk("t7_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("t7_busy_pre", busy, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t7_busy_post", busy, 0);
        repeat (12) @(negedge clk);
        chk("t7_done", done_cnt, 0);
        chk("t7_err", err, 0);
        chk("t7_go", go_cnt, 1);
        chk("t7_count", count, 0);
        stuck = 1'b0;

        // start with abort in IDLE
        clear_mon();
        lo = 16'd2; hi = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t8_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("t8_go", go_cnt, 0);
        chk("t8_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
